// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - two-client round-robin arbiter owning one shared WIDTH-bit register
module shared_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [3:0]         hold_q, hold_d;
    logic [WIDTH-1:0]   q_q, q_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            hold_q  <= 4'd0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || !ptr_q)) state_d = OWN0;
                else if (req1)                 state_d = OWN1;
            end
            OWN0: begin
                if (!req0)                         state_d = req1 ? OWN1 : IDLE;
                else if (req1 && hold_q == HOLD_LAST) state_d = OWN1;
            end
            OWN1: begin
                if (!req1)                         state_d = req0 ? OWN0 : IDLE;
                else if (req0 && hold_q == HOLD_LAST) state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh grant restarts the hold count and hands tie priority to the other client.
    always_comb begin
        ptr_d  = ptr_q;
        hold_d = hold_q;
        if (state_d == IDLE) begin
            hold_d = 4'd0;
        end else if (state_d != state_q) begin
            hold_d = 4'd0;
            ptr_d  = (state_d == OWN0);
        end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 4'd1;
        end
    end

    // The write is qualified by the grant held before the edge, not the next one.
    always_comb begin
        q_d = q_q;
        if (state_q == OWN0 && we0)      q_d = d0;
        else if (state_q == OWN1 && we1) q_d = d1;
    end

    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);
    assign busy = gnt0 | gnt1;
    assign q    = q_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - scoreboard bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] d0, d1;
    logic       gnt0, gnt1, busy;
    logic [7:0] q;

    typedef struct {
        logic       g0;
        logic       g1;
        logic [7:0] q;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    shared_reg_arbiter #(.WIDTH(8), .HOLD_MAX(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .we0  (we0),
        .we1  (we1),
        .d0   (d0),
        .d1   (d1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .q    (q),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drive one vector, queue the state expected after the coming edge, then wait past it.
    task automatic step(input logic r, input logic r0, input logic r1, input logic w0,
                        input logic w1, input logic [7:0] dd0, input logic [7:0] dd1,
                        input logic eg0, input logic eg1, input logic [7:0] eq);
        exp_t e;
        rst = r; req0 = r0; req1 = r1; we0 = w0; we1 = w1; d0 = dd0; d1 = dd1;
        e.g0 = eg0; e.g1 = eg1; e.q = eq;
        sb.push_back(e);
        @(posedge clk);
        #3;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            chk("grant_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gnt0", {31'd0, gnt0}, {31'd0, e.g0});
                chk("gnt1", {31'd0, gnt1}, {31'd0, e.g1});
                chk("busy", {31'd0, busy}, {31'd0, e.g0 | e.g1});
                chk("q",    {24'd0, q},    {24'd0, e.q});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end of directed sequence");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; d0 = 0; d1 = 0;
        #1;
        chk("async_reset_q",    {24'd0, q}, 32'd0);
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #3;

        // reset held with client 0 requesting and writing
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 8'hA5, 8'h00, 0, 0, 8'h00);
        step(1, 1, 0, 1, 0, 8'hA5, 8'h00, 1, 0, 8'h00);
        step(1, 1, 0, 1, 0, 8'hA5, 8'h00, 1, 0, 8'hA5);
        step(1, 0, 0, 0, 0, 8'hA5, 8'h00, 0, 0, 8'hA5);

        // single client 1
        step(1, 0, 1, 0, 1, 8'h00, 8'h3C, 0, 1, 8'hA5);
        step(1, 0, 1, 0, 1, 8'h00, 8'h3C, 0, 1, 8'h3C);
        step(1, 0, 0, 0, 0, 8'h00, 8'h3C, 0, 0, 8'h3C);

        // ties: ptr favours client 0 first, then client 1
        step(1, 1, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h3C);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h3C);
        step(1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h3C);

        // continuous contention: client 1 already has 1 cycle, blocks of 4 alternate
        for (int k = 1; k <= 16; k++) begin
            if (((k / 4) % 2) == 0) step(1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h3C);
            else                    step(1, 1, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h3C);
        end

        // handoff to client 0, then client 1 writes while ungranted
        step(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h3C);
        step(1, 1, 0, 1, 1, 8'h11, 8'hFF, 1, 0, 8'h11);
        step(1, 1, 0, 1, 1, 8'h11, 8'hFF, 1, 0, 8'h11);
        step(1, 0, 0, 1, 1, 8'h11, 8'hFF, 0, 0, 8'h11);
        step(1, 0, 0, 1, 1, 8'h22, 8'hFF, 0, 0, 8'h11);

        // client 1 owns q=3C, then reset between edges
        step(1, 0, 1, 0, 1, 8'h00, 8'h3C, 0, 1, 8'h11);
        step(1, 0, 1, 0, 1, 8'h00, 8'h3C, 0, 1, 8'h3C);
        rst = 1'b0;
        #1;
        chk("midreset_gnt1", {31'd0, gnt1}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_q",    {24'd0, q},    32'd0);
        step(1, 0, 1, 0, 1, 8'h00, 8'h3C, 0, 1, 8'h00);
        step(1, 0, 1, 0, 1, 8'h00, 8'h3C, 0, 1, 8'h3C);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h3C);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
